ds2_arbiter: RTL and testbench

Sequential arbiter that shares the 32-bit 2:1 data selector (DS2) between two requesters with valid/ready handshakes. It picks a requester round-robin and holds the grant for a burst. It drives the DS2 `select` line and registers the selected word into a one-stage output buffer feeding downstream datapath logic. It sits between two producers (e.g. ALU result path and memory read path) and a single consumer port.

---
 rtl/ds2_arbiter_pkg.sv | 13 +
 rtl/rr_pick2.sv | 18 +
 rtl/ds2_arbiter.sv | 139 +++++++++++++
 tb/tb_ds2_arbiter.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/ds2_arbiter_pkg.sv
// rtl/ds2_arbiter_pkg.sv - shared state encodings and defaults for the DS2 arbiter
package ds_arb_defs;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_e;

  localparam int DEF_WIDTH     = 32;
  localparam int DEF_MAX_BURST = 8;

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - combinational 2-way round-robin choice
module rr_pick2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       grant_idx,
  output logic       any
);

  // A lone requester wins outright; on a tie the one not granted last wins.
  always_comb begin
    any       = |valid;
    grant_idx = valid[1];
    if (&valid) begin
      grant_idx = ~last_grant;
    end
  end

endmodule

// File: rtl/ds2_arbiter.sv
// rtl/ds2_arbiter.sv - round-robin burst arbiter driving the DS2 select with a one-stage output buffer
module ds2_arbiter
  import ds_arb_defs::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  input  logic             req0_last,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  input  logic             req1_last,
  output logic             req1_ready,
  output logic             select,
  input  logic [WIDTH-1:0] mux_out,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  output logic             out_last,
  input  logic             out_ready
);

  localparam logic [7:0] MAX_BURST_C = 8'(MAX_BURST);

  arb_state_e       state_q, state_d;
  logic             select_q, select_d;
  logic             last_grant_q, last_grant_d;
  logic [7:0]       beat_cnt_q, beat_cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_src_q, out_src_d;
  logic             out_last_q, out_last_d;

  logic       pick_idx;
  logic       pick_any;
  logic       buf_free;
  logic       accept;
  logic       beat_last;
  logic       burst_done;
  logic [7:0] beat_cnt_inc;

  // Data words are unused here: the external DS2 returns the selected one on mux_out.
  rr_pick2 u_pick (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant_q),
    .grant_idx  (pick_idx),
    .any        (pick_any)
  );

  assign buf_free = !out_valid_q || out_ready;

  // Next-state, handshake and output-buffer logic.
  always_comb begin
    state_d      = state_q;
    select_d     = select_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_src_d    = out_src_q;
    out_last_d   = out_last_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    accept       = 1'b0;
    beat_last    = 1'b0;
    burst_done   = 1'b0;
    beat_cnt_inc = beat_cnt_q + 8'd1;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d      = pick_idx ? GRANT1 : GRANT0;
          last_grant_d = pick_idx;
          select_d     = pick_idx;
          beat_cnt_d   = 8'd0;
        end
      end
      GRANT0: begin
        req0_ready = buf_free;
        accept     = req0_valid && buf_free;
        beat_last  = req0_last;
      end
      GRANT1: begin
        req1_ready = buf_free;
        accept     = req1_valid && buf_free;
        beat_last  = req1_last;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      burst_done  = beat_last || (beat_cnt_inc == MAX_BURST_C);
      beat_cnt_d  = beat_cnt_inc;
      out_valid_d = 1'b1;
      out_data_d  = mux_out;
      out_src_d   = (state_q == GRANT1);
      out_last_d  = burst_done;
      if (burst_done) begin
        state_d = IDLE;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State and output-buffer registers; reset discards any buffered beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      select_q     <= 1'b0;
      last_grant_q <= 1'b1;
      beat_cnt_q   <= 8'd0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_src_q    <= 1'b0;
      out_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      select_q     <= select_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_src_q    <= out_src_d;
      out_last_q   <= out_last_d;
    end
  end

  assign select    = select_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_ds2_arbiter.sv
// tb/tb_ds2_arbiter.sv - directed table-driven bench for ds2_arbiter
module tb_ds2_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid;
  logic [31:0] req0_data;
  logic        req0_last;
  logic        req0_ready;
  logic        req1_valid;
  logic [31:0] req1_data;
  logic        req1_last;
  logic        req1_ready;
  logic        select;
  logic [31:0] mux_out;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_src;
  logic        out_last;
  logic        out_ready;

  int total;
  int passed;

  typedef struct {
    logic        rst;
    logic        v0;
    logic [31:0] d0;
    logic        l0;
    logic        v1;
    logic [31:0] d1;
    logic        l1;
    logic        ordy;
    logic        all;
    logic [37:0] exp;
  } vec_t;

  vec_t vecs[$];

  ds2_arbiter #(.WIDTH(32), .MAX_BURST(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_last  (req0_last),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_last  (req1_last),
    .req1_ready (req1_ready),
    .select     (select),
    .mux_out    (mux_out),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_src    (out_src),
    .out_last   (out_last),
    .out_ready  (out_ready)
  );

  // DS2 model: 0 selects data1/req0, 1 selects data2/req1.
  assign mux_out = select ? req1_data : req0_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic rst, input logic v0, input logic [31:0] d0, input logic l0,
                     input logic v1, input logic [31:0] d1, input logic l1, input logic ordy,
                     input logic all, input logic r0, input logic r1, input logic sel,
                     input logic ov, input logic os, input logic ol, input logic [31:0] od);
    vec_t v;
    v.rst = rst; v.v0 = v0; v.d0 = d0; v.l0 = l0;
    v.v1 = v1; v.d1 = d1; v.l1 = l1; v.ordy = ordy; v.all = all;
    v.exp = {r0, r1, sel, ov, os, ol, od};
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, want);
  endtask

  initial begin
    logic [37:0] got;
    logic [37:0] mask;
    int n;
    total = 0;
    passed = 0;
    rst_n = 1'b0; req0_valid = 1'b0; req0_data = '0; req0_last = 1'b0;
    req1_valid = 1'b0; req1_data = '0; req1_last = 1'b0; out_ready = 1'b1;

    // reset and idle: everything zero
    add(0, 0,0,0, 0,0,0, 1, 1,  0,0,0,0,0,0,32'h0);
    for (int i = 0; i < 5; i++) add(1, 0,0,0, 0,0,0, 1, 1,  0,0,0,0,0,0,32'h0);
    // alternation from reset: req0 wins first tie
    add(1, 1,32'hA0,1, 1,32'hB0,1, 1, 0,  0,0,0,0,0,0,0);
    add(1, 1,32'hA0,1, 1,32'hB0,1, 1, 0,  1,0,0,0,0,0,0);
    add(1, 1,32'hA0,1, 1,32'hB0,1, 1, 0,  0,0,0,1,0,1,32'hA0);
    add(1, 1,32'hA0,1, 1,32'hB0,1, 1, 0,  0,1,1,0,0,0,0);
    add(1, 1,32'hA0,1, 1,32'hB0,1, 1, 0,  0,0,1,1,1,1,32'hB0);
    add(1, 1,32'hA0,1, 1,32'hB0,1, 1, 0,  1,0,0,0,0,0,0);
    add(1, 1,32'hA0,1, 1,32'hB0,1, 1, 0,  0,0,0,1,0,1,32'hA0);
    add(1, 1,32'hA0,1, 1,32'hB0,1, 1, 0,  0,1,1,0,0,0,0);
    add(1, 0,0,0, 0,0,0, 1, 0,            0,0,1,1,1,1,32'hB0);
    // req0 three-beat burst
    add(1, 1,32'h11,0, 0,0,0, 1, 0,  0,0,1,0,0,0,0);
    add(1, 1,32'h11,0, 0,0,0, 1, 0,  1,0,0,0,0,0,0);
    add(1, 1,32'h22,0, 0,0,0, 1, 0,  1,0,0,1,0,0,32'h11);
    add(1, 1,32'h33,1, 0,0,0, 1, 0,  1,0,0,1,0,0,32'h22);
    add(1, 0,0,0, 0,0,0, 1, 0,       0,0,0,1,0,1,32'h33);
    add(1, 0,0,0, 0,0,0, 1, 0,       0,0,0,0,0,0,0);
    // req1 long stream, forced release at 8 beats
    add(1, 0,0,0, 1,32'h100,0, 1, 0,  0,0,0,0,0,0,0);
    add(1, 0,0,0, 1,32'h100,0, 1, 0,  0,1,1,0,0,0,0);
    for (int i = 1; i < 8; i++)
      add(1, 0,0,0, 1,32'h100+i,0, 1, 0,  0,1,1,1,1,0,32'h100+i-1);
    add(1, 0,0,0, 1,32'h108,0, 1, 0,  0,0,1,1,1,1,32'h107);
    add(1, 0,0,0, 1,32'h108,0, 1, 0,  0,1,1,0,0,0,0);
    add(1, 0,0,0, 1,32'h109,0, 1, 0,  0,1,1,1,1,0,32'h108);
    add(1, 0,0,0, 0,0,0, 1, 0,        0,1,1,1,1,0,32'h109);
    add(1, 0,0,0, 1,32'h10A,1, 1, 0,  0,1,1,0,0,0,0);
    add(1, 0,0,0, 0,0,0, 1, 0,        0,0,1,1,1,1,32'h10A);
    // backpressure mid-burst on req0
    add(1, 1,32'h201,0, 0,0,0, 1, 0,  0,0,1,0,0,0,0);
    add(1, 1,32'h201,0, 0,0,0, 1, 0,  1,0,0,0,0,0,0);
    for (int i = 0; i < 4; i++)
      add(1, 1,32'h202,0, 0,0,0, 0, 0,  0,0,0,1,0,0,32'h201);
    add(1, 1,32'h202,0, 0,0,0, 1, 0,  1,0,0,1,0,0,32'h201);
    add(1, 1,32'h203,0, 0,0,0, 1, 0,  1,0,0,1,0,0,32'h202);
    add(1, 1,32'h204,1, 0,0,0, 1, 0,  1,0,0,1,0,0,32'h203);
    add(1, 0,0,0, 0,0,0, 1, 0,        0,0,0,1,0,1,32'h204);
    add(1, 0,0,0, 0,0,0, 1, 0,        0,0,0,0,0,0,0);
    // reset pulse during GRANT1 with a buffered beat
    add(1, 0,0,0, 1,32'h301,0, 1, 0,  0,0,0,0,0,0,0);
    add(1, 0,0,0, 1,32'h301,0, 1, 0,  0,1,1,0,0,0,0);
    add(1, 0,0,0, 1,32'h302,0, 0, 0,  0,0,1,1,1,0,32'h301);
    add(0, 0,0,0, 1,32'h302,0, 0, 1,  0,0,0,0,0,0,32'h0);
    add(1, 1,32'hA0,1, 1,32'hB0,1, 1, 1,  0,0,0,0,0,0,32'h0);
    add(1, 1,32'hA0,1, 1,32'hB0,1, 1, 0,  1,0,0,0,0,0,0);
    add(1, 0,0,0, 0,0,0, 1, 0,        0,0,0,1,0,1,32'hA0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst_n = vecs[i].rst;
      req0_valid = vecs[i].v0; req0_data = vecs[i].d0; req0_last = vecs[i].l0;
      req1_valid = vecs[i].v1; req1_data = vecs[i].d1; req1_last = vecs[i].l1;
      out_ready = vecs[i].ordy;
      #1;
      got  = {req0_ready, req1_ready, select, out_valid, out_src, out_last, out_data};
      mask = {4'hF, {34{vecs[i].all | vecs[i].exp[34]}}};
      check($sformatf("vec%0d", i), 64'(got & mask), 64'(vecs[i].exp & mask));
    end

    // single req1 beat: first out_valid two cycles after valid
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b1; req1_data = 32'hCAFE; req1_last = 1'b1; out_ready = 1'b1;
    n = 0;
    while (!out_valid && n < 10) begin
      @(negedge clk);
      n++;
      #1;
    end
    req1_valid = 1'b0;
    check("latency", 64'(n), 64'd2);
    check("single_beat", 64'({out_valid, out_src, out_last, out_data}), 64'({3'b111, 32'hCAFE}));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
